// File: rtl/pwm_breath_ctrl.sv
// Breathing-LED brightness sequencer feeding a downstream PWM stage.
// Optional macro PWM_BREATH_GAMMA_EN selects a quadratic gamma curve for brightness.
module pwm_breath_ctrl #(
   parameter int FREQ_W = 32
) (
   input  logic              i_sysclk,
   input  logic              i_resetn,
   input  logic              i_enable,
   input  logic [31:0]       i_step_cnt,
   input  logic [15:0]       i_hold_cnt,
   input  logic [7:0]        i_min_level,
   input  logic [7:0]        i_max_level,
   input  logic [FREQ_W-1:0] i_freq_cnt,
   output logic [7:0]        o_brightness,
   output logic [FREQ_W-1:0] o_duty_cnt,
   output logic              o_update,
   output logic [2:0]        o_phase
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD_HIGH = 3'd2,
      RAMP_DOWN = 3'd3,
      HOLD_LOW  = 3'd4
   } phase_t;

   phase_t        state, state_nxt;
   logic [7:0]    level, level_nxt;
   logic [31:0]   clk_cnt, clk_cnt_nxt;
   logic [15:0]   hold_q, hold_nxt;
   logic          upd_pend, upd_pend_nxt;

   logic [31:0]        step_term;
   logic               tick;
   logic               degenerate;
   logic               hold_done;
   logic [7:0]         bright_val;
   logic [FREQ_W+7:0]  duty_prod;
   logic               duty_unused;

   // A step count of 0 behaves like 1; >= keeps the tick alive if the step count shrinks mid-count.
   assign step_term  = (i_step_cnt == 32'd0) ? 32'd0 : (i_step_cnt - 32'd1);
   assign tick       = (state != IDLE) && (clk_cnt >= step_term);
   assign degenerate = (i_min_level >= i_max_level);
   assign hold_done  = (({1'b0, hold_q} + 17'd1) >= {1'b0, i_hold_cnt});

`ifdef PWM_BREATH_GAMMA_EN
   logic [15:0] gamma_prod;
   logic        gamma_unused;
   assign gamma_prod   = {8'd0, level} * ({8'd0, level} + 16'd1);
   assign bright_val   = gamma_prod[15:8];
   assign gamma_unused = ^gamma_prod[7:0];
`else
   assign bright_val = level;
`endif

   assign duty_prod   = {8'd0, i_freq_cnt} * {{FREQ_W{1'b0}}, bright_val};
   assign duty_unused = ^duty_prod[7:0];

   always_comb begin
      state_nxt   = state;
      level_nxt   = level;
      clk_cnt_nxt = clk_cnt;
      hold_nxt    = hold_q;
      if (!i_enable) begin
         state_nxt   = IDLE;
         level_nxt   = 8'd0;
         clk_cnt_nxt = 32'd0;
         hold_nxt    = 16'd0;
      end else if (state == IDLE) begin
         state_nxt   = RAMP_UP;
         level_nxt   = i_min_level;
         clk_cnt_nxt = 32'd0;
         hold_nxt    = 16'd0;
      end else begin
         clk_cnt_nxt = tick ? 32'd0 : (clk_cnt + 32'd1);
         if (degenerate) begin
            state_nxt = HOLD_HIGH;
            level_nxt = i_max_level;
            hold_nxt  = 16'd0;
         end else if (tick) begin
            // Bounds are compared one step ahead so level never wraps past 0 or 255.
            case (state)
               RAMP_UP: begin
                  if (level >= (i_max_level - 8'd1)) begin
                     level_nxt = i_max_level;
                     state_nxt = (i_hold_cnt == 16'd0) ? RAMP_DOWN : HOLD_HIGH;
                     hold_nxt  = 16'd0;
                  end else begin
                     level_nxt = level + 8'd1;
                  end
               end
               RAMP_DOWN: begin
                  if (level <= (i_min_level + 8'd1)) begin
                     level_nxt = i_min_level;
                     state_nxt = (i_hold_cnt == 16'd0) ? RAMP_UP : HOLD_LOW;
                     hold_nxt  = 16'd0;
                  end else begin
                     level_nxt = level - 8'd1;
                  end
               end
               HOLD_HIGH: begin
                  if (hold_done) begin
                     state_nxt = RAMP_DOWN;
                     hold_nxt  = 16'd0;
                  end else begin
                     hold_nxt = hold_q + 16'd1;
                  end
               end
               HOLD_LOW: begin
                  if (hold_done) begin
                     state_nxt = RAMP_UP;
                     hold_nxt  = 16'd0;
                  end else begin
                     hold_nxt = hold_q + 16'd1;
                  end
               end
               default: begin
                  state_nxt = IDLE;
               end
            endcase
         end
      end
      upd_pend_nxt = (level_nxt != level) || (!i_enable && (state != IDLE));
   end

   always_ff @(posedge i_sysclk or negedge i_resetn) begin
      if (!i_resetn) begin
         state    <= IDLE;
         level    <= 8'd0;
         clk_cnt  <= 32'd0;
         hold_q   <= 16'd0;
         upd_pend <= 1'b0;
      end else begin
         state    <= state_nxt;
         level    <= level_nxt;
         clk_cnt  <= clk_cnt_nxt;
         hold_q   <= hold_nxt;
         upd_pend <= upd_pend_nxt;
      end
   end

   // Outputs trail the level register by one cycle so brightness, duty and the pulse move together.
   always_ff @(posedge i_sysclk or negedge i_resetn) begin
      if (!i_resetn) begin
         o_brightness <= 8'd0;
         o_duty_cnt   <= '0;
         o_update     <= 1'b0;
      end else begin
         o_update <= upd_pend;
         if (upd_pend) begin
            o_brightness <= bright_val;
            o_duty_cnt   <= duty_prod[FREQ_W+7:8];
         end
      end
   end

   assign o_phase = state;

endmodule

// File: doc/pwm_breath_ctrl.md
PWM_BREATH_CTRL -- requirements
Module: pwm_breath_ctrl

Interface
REQ-001 SHALL have parameter FREQ_W, default 32, width of period and duty counts.
REQ-002 SHALL have port i_sysclk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port i_resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_enable  input  1  1 = breathing runs, 0 = idle.
REQ-005 SHALL have port i_step_cnt  input  32  clocks per brightness step; 0 is treated as 1.
REQ-006 SHALL have port i_hold_cnt  input  16  steps spent at each extreme; 0 means no hold.
REQ-007 SHALL have port i_min_level  input  8  lower brightness bound.
REQ-008 SHALL have port i_max_level  input  8  upper brightness bound.
REQ-009 SHALL have port i_freq_cnt  input  FREQ_W  PWM period count of the downstream PWM stage.
REQ-010 SHALL have port o_brightness  output  8  brightness value for the PWM stage.
REQ-011 SHALL have port o_duty_cnt  output  FREQ_W  duty count for the PWM stage.
REQ-012 SHALL have port o_update  output  1  one-cycle pulse marking new outputs.
REQ-013 SHALL have port o_phase  output  3  current state encoding.

Function
REQ-014 SHALL implement a state machine with encodings IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3 and HOLD_LOW=4, reported on o_phase.
REQ-015 SHALL generate a step tick from a clock counter that counts 0..max(i_step_cnt,1)-1, asserting the tick in the cycle where the count equals the terminal value, then wrapping to 0.
REQ-016 SHALL, in IDLE with i_enable=1, load level=i_min_level, clear both counters and enter RAMP_UP on the next edge.
REQ-017 SHALL, in RAMP_UP on a tick, increment level by 1; when the new level reaches i_max_level, enter HOLD_HIGH, or RAMP_DOWN directly if i_hold_cnt=0.
REQ-018 SHALL, in RAMP_DOWN on a tick, decrement level by 1; when the new level reaches i_min_level, enter HOLD_LOW, or RAMP_UP directly if i_hold_cnt=0.
REQ-019 SHALL keep level unchanged in HOLD_HIGH and HOLD_LOW for exactly i_hold_cnt ticks, then leave on the tick that completes the count: HOLD_HIGH to RAMP_DOWN, HOLD_LOW to RAMP_UP.
REQ-020 SHALL, on a tick in RAMP_UP with level above i_max_level, clamp level to i_max_level and apply the reach-max transition.
REQ-021 SHALL, on a tick in RAMP_DOWN with level below i_min_level, clamp level to i_min_level and apply the reach-min transition.
REQ-022 SHALL, when i_min_level >= i_max_level and not in IDLE, force level to i_max_level and hold state HOLD_HIGH; no ramping occurs.
REQ-023 SHALL never wrap level beyond 0 or 255.
REQ-024 SHALL, when i_enable=0 in any state, enter IDLE on the next edge, clear the counters and drive o_brightness=0 and o_duty_cnt=0 with one o_update pulse.
REQ-025 SHALL register o_brightness, o_duty_cnt and o_update together exactly one cycle after the edge that changes level, with o_update=1 for that single cycle only.
REQ-026 SHALL compute o_duty_cnt = (i_freq_cnt * o_brightness_value) >> 8 using a full FREQ_W+8-bit product truncated to FREQ_W bits.

Reset
REQ-027 SHALL, while i_resetn=0, hold state IDLE, level 0, both counters 0, o_brightness 0, o_duty_cnt 0, o_update 0 and o_phase 0, independent of the clock.
REQ-028 SHALL, after reset release, remain in IDLE until i_enable is sampled 1.

Configuration
REQ-029 SHALL support macro PWM_BREATH_GAMMA_EN; when it is defined, brightness = (level*(level+1))>>8, mapping 0 to 0 and 255 to 255; when it is undefined, brightness = level.
REQ-030 SHALL apply the REQ-029 mapping before the REQ-026 duty computation.

Verification
REQ-031 SHALL cover: step=4, hold=2, min=0, max=3, freq=256, enable at t0 -> brightness 1,2,3 at 4-clock spacing, held 8 clocks, then 2,1,0, held 8 clocks, repeating; duty equals brightness.
REQ-032 SHALL cover: hold=0, min=10, max=12 -> brightness 11,12,11,10,11 with no repeated value at the extremes.
REQ-033 SHALL cover: deassert enable mid-RAMP_UP at level 100 -> o_phase=0 next edge, one o_update with brightness=0 and duty=0.
REQ-034 SHALL cover: lower max from 200 to 50 while level=120 in RAMP_UP -> next tick brightness=50 and phase HOLD_HIGH.
REQ-035 SHALL cover: min=max=80, freq=16384 -> brightness 80 constant, duty 5120, phase 2; with PWM_BREATH_GAMMA_EN defined, brightness 25, duty 1600.
REQ-036 SHALL cover: assert reset mid-HOLD_LOW -> all outputs 0 immediately without a clock edge; after release with enable=1, the ramp restarts from min.
